// File: rtl/deb_sync.sv
// deb_sync: synchroniser + stability-counter debouncer for asynchronous,
// bouncy inputs. Produces a clean level, one-cycle rise/fall strobes and a
// one-shot long-press strobe. Counters advance only on qualified (ce=1) cycles.
module deb_sync #(
  parameter int SYNC_STAGES = 2,      // >= 2
  parameter int DEB_CNT     = 1000,   // >= 1
  parameter int LONG_CNT    = 50000,  // >= 1
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic ce,
  output logic q,
  output logic rise,
  output logic fall,
  output logic lng
);

  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int LW = $clog2(LONG_CNT + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [DW-1:0]          dcnt;
  logic [DW-1:0]          dcnt_next;
  logic                   accept;
  logic                   q_next;
  logic [LW-1:0]          lcnt;
  logic                   done;

  // Synchroniser chain: nothing else touches 'in' before the last stage.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the pre-edge values of the others, which is what makes the
    // chain shift instead of collapsing into a single stage.
    if (rst) sync <= {SYNC_STAGES{INIT_LEVEL}};
    else     sync <= {sync[SYNC_STAGES-2:0], in};
  end

  assign s = sync[SYNC_STAGES-1];

  // Debounce decision: accept s once it has differed from q for DEB_CNT
  // qualified cycles; any agreement with q restarts the count, even if ce=0.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch
    // can be inferred.
    dcnt_next = dcnt;
    accept    = 1'b0;
    if (s == q) begin
      dcnt_next = '0;
    end else if (ce) begin
      if (dcnt == DEB_LAST) begin
        accept    = 1'b1;
        dcnt_next = '0;
      end else begin
        dcnt_next = dcnt + 1'b1;
      end
    end
  end

  assign q_next = accept ? s : q;

  // Debounced level and edge strobes, registered together so a strobe lines
  // up with the first cycle q shows the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      q    <= INIT_LEVEL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      dcnt <= dcnt_next;
      q    <= q_next;
      rise <= accept & s;
      fall <= accept & ~s;
    end
  end

  // Long-press timer: one lng per high period, re-armed when q goes low.
  // A falling q wins over a lng that would fire in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt <= '0;
      done <= 1'b0;
      lng  <= 1'b0;
    end else begin
      lng <= 1'b0;
      if (!q || !q_next) begin
        lcnt <= '0;
        done <= 1'b0;
      end else if (ce && !done) begin
        if (lcnt == LONG_LAST) begin
          lng  <= 1'b1;
          done <= 1'b1;
        end else begin
          lcnt <= lcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_deb_sync.sv
// tb_deb_sync: table-driven vectors plus hand-written sequences, with a
// reference model feeding a scoreboard queue on every clock.
module tb_deb_sync;

  localparam int DEB  = 4;
  localparam int LONG = 8;

  logic clk = 1'b0;
  logic rst, in, ce;
  logic q, rise, fall, lng;
  logic in1;
  logic q1, rise1, fall1, lng1;

  always #5 clk = ~clk;

  deb_sync #(.SYNC_STAGES(2), .DEB_CNT(DEB), .LONG_CNT(LONG), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in(in), .ce(ce),
    .q(q), .rise(rise), .fall(fall), .lng(lng)
  );

  // Second instance: INIT_LEVEL=1 with in held high must never strobe.
  deb_sync #(.SYNC_STAGES(2), .DEB_CNT(DEB), .LONG_CNT(LONG), .INIT_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .ce(ce),
    .q(q1), .rise(rise1), .fall(fall1), .lng(lng1)
  );

  typedef struct packed {
    logic       r;
    logic       i;
    logic       c;
    logic [3:0] exp;   // {q, rise, fall, lng}
  } vec_t;

  vec_t       tbl [16];
  logic [3:0] sb [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rise_cnt = 0, fall_cnt = 0, lng_cnt = 0;
  int rise_cyc = -1, fall_cyc = -1, lng_cyc = -1;
  int viol1 = 0;

  // Reference model state
  logic m_s0, m_s1, m_q, m_rise, m_fall, m_lng, m_done;
  int   m_d, m_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input logic r, input logic i, input logic c);
    logic s_now, acc, nq;
    if (r) begin
      m_s0 = 1'b0; m_s1 = 1'b0; m_q = 1'b0; m_d = 0; m_l = 0; m_done = 1'b0;
      m_rise = 1'b0; m_fall = 1'b0; m_lng = 1'b0;
    end else begin
      s_now = m_s1;
      acc   = c && (s_now != m_q) && (m_d == DEB - 1);
      nq    = acc ? s_now : m_q;
      m_lng = 1'b0;
      if (!m_q || !nq) begin
        m_l = 0; m_done = 1'b0;
      end else if (c && !m_done) begin
        if (m_l == LONG - 1) begin m_lng = 1'b1; m_done = 1'b1; end
        else m_l++;
      end
      if (s_now == m_q || acc) m_d = 0;
      else if (c) m_d++;
      m_rise = acc && s_now;
      m_fall = acc && !s_now;
      m_q    = nq;
      m_s1   = m_s0;
      m_s0   = i;
    end
  endtask

  // One clock: drive, predict, let the edge happen, compare, log events.
  task automatic step(input logic r, input logic i, input logic c);
    logic [3:0] want;
    rst = r; in = i; ce = c;
    model(r, i, c);
    sb.push_back({m_q, m_rise, m_fall, m_lng});
    @(posedge clk);
    #1;
    cyc++;
    want = sb.pop_front();
    check("scoreboard", {28'd0, q, rise, fall, lng}, {28'd0, want});
    if (rise) begin rise_cnt++; rise_cyc = cyc; end
    if (fall) begin fall_cnt++; fall_cyc = cyc; end
    if (lng)  begin lng_cnt++;  lng_cyc  = cyc; end
    if (q1 !== 1'b1 || rise1 !== 1'b0 || fall1 !== 1'b0) viol1++;
  endtask

  initial begin
    int base, ts, tp, tr, rc0, fc0, lc0;
    rst = 1'b1; in = 1'b0; ce = 1'b1; in1 = 1'b1;

    // Clean edge, then an 8-cycle high whose fall coincides with the cycle
    // lng would fire: the fall must suppress lng.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 4'b0000};
    for (int k = 1; k <= 5; k++) tbl[k] = '{1'b0, 1'b1, 1'b1, 4'b0000};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 4'b1100};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 4'b1000};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 4'b1000};
    for (int k = 9; k <= 13; k++) tbl[k] = '{1'b0, 1'b0, 1'b1, 4'b1000};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 4'b0010};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 4'b0000};

    step(1'b1, 1'b0, 1'b1);
    check("reset_state", {28'd0, q, rise, fall, lng}, 32'd0);

    for (int k = 0; k < 16; k++) begin
      step(tbl[k].r, tbl[k].i, tbl[k].c);
      check($sformatf("table[%0d]", k), {28'd0, q, rise, fall, lng}, {28'd0, tbl[k].exp});
    end
    check("table_no_lng", lng_cnt, 0);

    // Bounce: 1,0,1,0 then hold 1; exactly one rise, 5 edges after the
    // sampling edge of the final 0->1.
    rise_cnt = 0; lng_cnt = 0;
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1);
    ts = cyc + 1;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b1);
    check("bounce_one_rise", rise_cnt, 1);
    check("bounce_rise_time", rise_cyc, ts + 5);

    // Long press: lng once, 8 edges after rise; re-arms after release.
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b1);
    check("long_one_lng", lng_cnt, 1);
    check("long_lng_time", lng_cyc, rise_cyc + LONG);
    tr = cyc + 1;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1);
    check("long_fall_time", fall_cyc, tr + 5);
    tp = cyc + 1;
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b1);
    check("repress_rise_time", rise_cyc, tp + 5);
    check("repress_lng_cnt", lng_cnt, 2);
    check("repress_lng_time", lng_cyc, rise_cyc + LONG);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1);

    // Short press: q high for 7 cycles, no lng.
    tp = cyc + 1;
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b1);
    tr = cyc + 1;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1);
    check("short_rise_time", rise_cyc, tp + 5);
    check("short_fall_time", fall_cyc, tr + 5);
    check("short_no_lng", lng_cnt, 2);

    // ce every 4th cycle: rise after 2 sync edges plus 4 ce pulses.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
    base = cyc + 1;
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, (k % 4) == 3);
    check("ce_rise_time", rise_cyc, base + 15);
    // A one-cycle return of s to q while ce=0 restarts the count.
    base = cyc + 1;
    for (int k = 0; k < 28; k++) step(1'b0, (k == 7), (k % 4) == 3);
    check("ce_clear_fall_time", fall_cyc, base + 23);

    // Reset mid-debounce (dcnt=2), then mid-hold (lcnt=5).
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1);
    rc0 = rise_cnt; fc0 = fall_cnt; lc0 = lng_cnt;
    base = cyc + 1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_debounce_q", q, 1'b0);
    check("rst_debounce_no_rise", rise_cnt, rc0);
    for (int k = 5; k <= 15; k++) step(1'b0, 1'b1, 1'b1);
    check("rst_restart_rise_time", rise_cyc, base + 10);
    step(1'b1, 1'b1, 1'b1);
    check("rst_hold_q", q, 1'b0);
    check("rst_hold_no_fall", fall_cnt, fc0);
    check("rst_hold_no_lng", lng_cnt, lc0);
    for (int k = 17; k <= 30; k++) step(1'b0, 1'b1, 1'b1);
    check("rst_rearm_rise_time", rise_cyc, base + 22);
    check("rst_rearm_lng_time", lng_cyc, base + 30);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1);

    check("init1_no_strobe", viol1, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
